periph_bus_arbiter: RTL

Two-master arbiter and transaction sequencer for the 16-bit peripheral register bus (cs/addr/rd/wr/d_in/d_out) that drives `peripheral_control_movimiento`. It lets the CPU core (master 0) and the UART command decoder (master 1) share the motion peripheral. It serialises their single-register reads and writes and returns read data and completion acks to each master. Arbitration is round-robin, with an optional bounded lock for multi-register update sequences.

---
 rtl/periph_bus_arbiter.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/periph_bus_arbiter.sv
// Two-master round-robin arbiter and transaction sequencer for the 16-bit
// motion peripheral register bus, with a bounded lock for multi-register updates.
module periph_bus_arbiter #(
   parameter int READ_LAT = 1,
   parameter int LOCK_MAX = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        m0_req,
   input  logic        m1_req,
   input  logic        m0_wr,
   input  logic        m1_wr,
   input  logic [3:0]  m0_addr,
   input  logic [3:0]  m1_addr,
   input  logic [15:0] m0_wdata,
   input  logic [15:0] m1_wdata,
   input  logic        m0_lock,
   input  logic        m1_lock,
   output logic        m0_ack,
   output logic        m1_ack,
   output logic [15:0] m0_rdata,
   output logic [15:0] m1_rdata,
   output logic        p_cs,
   output logic        p_rd,
   output logic        p_wr,
   output logic [3:0]  p_addr,
   output logic [15:0] p_din,
   input  logic [15:0] p_dout,
   output logic        busy,
   output logic        owner
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

   localparam logic [2:0] WAIT_INIT  = 3'(READ_LAT - 1);
   localparam logic [3:0] LOCK_LIMIT = 4'(LOCK_MAX);

   state_t      state_q;
   logic        owner_q;
   logic        last_q;
   logic        lock_act_q;
   logic [3:0]  lock_cnt_q;
   logic        cmd_wr_q;
   logic        cmd_lock_q;
   logic [2:0]  wait_cnt_q;
   logic        p_cs_q, p_rd_q, p_wr_q;
   logic [3:0]  p_addr_q;
   logic [15:0] p_din_q;
   logic        m0_ack_q, m1_ack_q;
   logic [15:0] m0_rdata_q, m1_rdata_q;

   logic        own_req, oth_req;
   logic        grant_vld, grant_idx;
   logic        sel_wr, sel_lock;
   logic [3:0]  sel_addr;
   logic [15:0] sel_wdata;

   // A held lock excludes the other master until LOCK_LIMIT is reached while it waits.
   always_comb begin
      own_req   = owner_q ? m1_req : m0_req;
      oth_req   = owner_q ? m0_req : m1_req;
      grant_vld = 1'b0;
      grant_idx = owner_q;
      if (lock_act_q && ((lock_cnt_q < LOCK_LIMIT) || !oth_req)) begin
         grant_vld = own_req;
      end else if (m0_req && m1_req) begin
         grant_vld = 1'b1;
         grant_idx = ~last_q;
      end else if (m0_req || m1_req) begin
         grant_vld = 1'b1;
         grant_idx = m1_req;
      end
   end

   assign sel_wr    = grant_idx ? m1_wr    : m0_wr;
   assign sel_lock  = grant_idx ? m1_lock  : m0_lock;
   assign sel_addr  = grant_idx ? m1_addr  : m0_addr;
   assign sel_wdata = grant_idx ? m1_wdata : m0_wdata;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         owner_q    <= 1'b0;
         last_q     <= 1'b1;
         lock_act_q <= 1'b0;
         lock_cnt_q <= 4'd0;
         cmd_wr_q   <= 1'b0;
         cmd_lock_q <= 1'b0;
         wait_cnt_q <= 3'd0;
         p_cs_q     <= 1'b0;
         p_rd_q     <= 1'b0;
         p_wr_q     <= 1'b0;
         p_addr_q   <= 4'd0;
         p_din_q    <= 16'd0;
         m0_ack_q   <= 1'b0;
         m1_ack_q   <= 1'b0;
         m0_rdata_q <= 16'd0;
         m1_rdata_q <= 16'd0;
      end else begin
         case (state_q)
            IDLE: begin
               if (grant_vld) begin
                  owner_q    <= grant_idx;
                  last_q     <= grant_idx;
                  cmd_wr_q   <= sel_wr;
                  cmd_lock_q <= sel_lock;
                  p_addr_q   <= sel_addr;
                  p_din_q    <= sel_wdata;
                  p_cs_q     <= 1'b1;
                  p_wr_q     <= sel_wr;
                  p_rd_q     <= ~sel_wr;
                  if (grant_idx != owner_q) begin
                     lock_act_q <= 1'b0;
                     lock_cnt_q <= 4'd0;
                  end
                  state_q <= ISSUE;
               end
            end
            ISSUE: begin
               p_cs_q     <= 1'b0;
               p_rd_q     <= 1'b0;
               p_wr_q     <= 1'b0;
               wait_cnt_q <= WAIT_INIT;
               if (cmd_wr_q) begin
                  m0_ack_q <= ~owner_q;
                  m1_ack_q <= owner_q;
                  state_q  <= ACK;
               end else begin
                  state_q <= WAIT;
               end
            end
            WAIT: begin
               if (wait_cnt_q == 3'd0) begin
                  if (owner_q) m1_rdata_q <= p_dout;
                  else         m0_rdata_q <= p_dout;
                  m0_ack_q <= ~owner_q;
                  m1_ack_q <= owner_q;
                  state_q  <= ACK;
               end else begin
                  wait_cnt_q <= wait_cnt_q - 3'd1;
               end
            end
            ACK: begin
               m0_ack_q <= 1'b0;
               m1_ack_q <= 1'b0;
               if (cmd_lock_q) begin
                  lock_act_q <= 1'b1;
                  lock_cnt_q <= (lock_cnt_q == 4'hF) ? 4'hF : lock_cnt_q + 4'd1;
               end else begin
                  lock_act_q <= 1'b0;
                  lock_cnt_q <= 4'd0;
               end
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign m0_ack   = m0_ack_q;
   assign m1_ack   = m1_ack_q;
   assign m0_rdata = m0_rdata_q;
   assign m1_rdata = m1_rdata_q;
   assign p_cs     = p_cs_q;
   assign p_rd     = p_rd_q;
   assign p_wr     = p_wr_q;
   assign p_addr   = p_addr_q;
   assign p_din    = p_din_q;
   assign busy     = (state_q != IDLE);
   assign owner    = owner_q;

endmodule
